// File: rtl/pmu_pkg.sv
// Shared definitions for the PAD power-mode sequencer: mode encoding and
// PAD drive-strength codes.
package pmu_pkg;

   // Power modes, encoded as they appear on mode_out
   typedef enum logic [1:0] {
      ACTIVE = 2'b00,
      LIGHT  = 2'b01,
      DEEP   = 2'b10,
      WAKE   = 2'b11
   } pmu_mode_e;

   // PAD drive strengths
   localparam logic [1:0] DRV_FULL = 2'b11;
   localparam logic [1:0] DRV_LOW  = 2'b01;
   localparam logic [1:0] DRV_OFF  = 2'b00;

endpackage

// File: rtl/pmu_cycle_counter.sv
// Saturating cycle counter shared by all power modes. Clear wins over
// increment; the count sticks at all-ones instead of wrapping. The terminal
// flag compares the current count against a caller-selected value.
module pmu_cycle_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [CNT_W-1:0] i_term,
   output logic             o_at_term
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt;

   // Count register: clear, saturating increment, or hold
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_at_term = (r_cnt == i_term);

endmodule

// File: rtl/power_mode_controller.sv
// PAD power-mode sequencer: ACTIVE -> LIGHT on idle timeout or sleep request,
// LIGHT -> DEEP on a longer idle timeout, DEEP -> WAKE on wake/activity and
// WAKE -> ACTIVE after a fixed number of cycles. All outputs are registered
// decodes of the next mode.
// Build option: define PMU_DEEP_SLEEP_EN to generate the DEEP/WAKE modes.
// Without it LIGHT is the deepest mode, clk_en_out is tied 1 and
// pad_hold_out is tied 0.
module power_mode_controller
   import pmu_pkg::*;
#(
   parameter int IDLE_CYCLES = 16,
   parameter int DEEP_CYCLES = 64,
   parameter int WAKE_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       activity_in,
   input  logic       sleep_req,
   input  logic       wake_req,
   output logic [1:0] mode_out,
   output logic       clk_en_out,
   output logic [1:0] pad_drive_out,
   output logic       pad_hold_out,
   output logic       mode_chg_pulse
);

   // Terminal counts: a mode times out on the cycle its counter equals these.
   // In WAKE the counter is compared one short of the end so that the hold
   // release can be registered ahead of the final WAKE cycle.
   localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEEP_TERM = CNT_W'(DEEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_PRE  = CNT_W'((WAKE_CYCLES >= 2) ? (WAKE_CYCLES - 2) : 0);

   pmu_mode_e        r_state;
   pmu_mode_e        w_state_nxt;
   logic [1:0]       r_drive;
   logic             r_pulse;
   logic             w_clr;
   logic             w_inc;
   logic             w_at_term;
   logic [CNT_W-1:0] w_term;

   pmu_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .i_clr     (w_clr),
      .i_inc     (w_inc),
      .i_term    (w_term),
      .o_at_term (w_at_term)
   );

`ifdef PMU_DEEP_SLEEP_EN
   logic r_clk_en;
   logic r_hold;
`endif

   // Select the timeout value that applies to the current mode
   always_comb begin
      w_term = WAKE_PRE;
      case (r_state)
         ACTIVE:  w_term = IDLE_TERM;
         LIGHT:   w_term = DEEP_TERM;
         default: w_term = WAKE_PRE;
      endcase
   end

   // Next-mode and counter control; any mode change also clears the counter
   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_inc       = 1'b0;
      case (r_state)
         ACTIVE: begin
            // activity beats sleep_req; wake_req masks sleep_req
            if (activity_in) begin
               w_clr = 1'b1;
            end else if ((sleep_req && !wake_req) || w_at_term) begin
               w_state_nxt = LIGHT;
            end else begin
               w_inc = 1'b1;
            end
         end
         LIGHT: begin
            if (activity_in || wake_req) begin
               w_state_nxt = ACTIVE;
`ifdef PMU_DEEP_SLEEP_EN
            end else if (w_at_term) begin
               w_state_nxt = DEEP;
`endif
            end else begin
               w_inc = 1'b1;
            end
         end
`ifdef PMU_DEEP_SLEEP_EN
         DEEP: begin
            w_clr = 1'b1;
            if (wake_req || activity_in) begin
               w_state_nxt = WAKE;
            end
         end
         WAKE: begin
            // hold already dropped means this is the final WAKE cycle
            if (!r_hold) begin
               w_state_nxt = ACTIVE;
            end else begin
               w_inc = 1'b1;
            end
         end
`endif
         default: begin
            w_state_nxt = ACTIVE;
         end
      endcase
      if (w_state_nxt != r_state) begin
         w_clr = 1'b1;
      end
   end

   // Mode register with registered drive decode and change pulse
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= ACTIVE;
         r_drive <= DRV_FULL;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pulse <= (w_state_nxt != r_state);
         case (w_state_nxt)
            ACTIVE:  r_drive <= DRV_FULL;
`ifdef PMU_DEEP_SLEEP_EN
            DEEP:    r_drive <= DRV_OFF;
`endif
            default: r_drive <= DRV_LOW;
         endcase
      end
   end

`ifdef PMU_DEEP_SLEEP_EN
   // Clock-enable and retention decode; hold releases one cycle before WAKE ends
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_clk_en <= 1'b1;
         r_hold   <= 1'b0;
      end else begin
         r_clk_en <= (w_state_nxt != DEEP);
         case (w_state_nxt)
            DEEP:    r_hold <= 1'b1;
            WAKE:    r_hold <= (r_state == WAKE) ? !w_at_term : (WAKE_CYCLES != 1);
            default: r_hold <= 1'b0;
         endcase
      end
   end

   assign clk_en_out   = r_clk_en;
   assign pad_hold_out = r_hold;
`else
   assign clk_en_out   = 1'b1;
   assign pad_hold_out = 1'b0;
`endif

   assign mode_out       = r_state;
   assign pad_drive_out  = r_drive;
   assign mode_chg_pulse = r_pulse;

endmodule

// File: doc/power_mode_controller.md
# power_mode_controller

Power-mode sequencer for the adaptive PAD controller, clocked by the clock-management unit's buffered clock and reset by its synchronised reset. It watches PAD activity and explicit sleep/wake requests and steps through ACTIVE, LIGHT, DEEP and WAKE modes. From the current mode it drives a clock-enable for the downstream integrated clock gate, the PAD drive strength and the PAD hold (retention) control. The block itself always runs on the ungated clock.

## Interface
- IDLE_CYCLES, 16: consecutive inactive cycles in ACTIVE before entering LIGHT.
- DEEP_CYCLES, 64: consecutive inactive cycles in LIGHT before entering DEEP.
- WAKE_CYCLES, 4: cycles spent in WAKE before returning to ACTIVE.
- CNT_W, 8: width of the shared cycle counter; every *_CYCLES value is in 1..2^CNT_W-1.
- clk_in  input  1  ungated system clock from the clock-management unit.
- rst_n_in  input  1  asynchronous active-low reset (already synchronously deasserted upstream).
- activity_in  input  1  PAD traffic seen this cycle.
- sleep_req  input  1  level request to force LIGHT immediately.
- wake_req  input  1  level request to leave LIGHT/DEEP.
- mode_out  output  2  current mode: 00 ACTIVE, 01 LIGHT, 10 DEEP, 11 WAKE.
- clk_en_out  output  1  enable to the downstream clock gate.
- pad_drive_out  output  2  PAD drive strength: 11 full, 01 reduced, 00 off.
- pad_hold_out  output  1  PAD retention/hold.
- mode_chg_pulse  output  1  one-cycle pulse on every mode change.

## Operation
- The FSM is one state register plus one CNT_W-bit counter. The counter clears on every state change.
- ACTIVE:
  - Counter increments on cycles with activity_in=0 and clears on cycles with activity_in=1.
  - Goes to LIGHT when sleep_req=1 or when the counter reaches IDLE_CYCLES-1 with activity_in=0.
- LIGHT:
  - activity_in=1 or wake_req=1 goes to ACTIVE.
  - Otherwise the counter increments, and the FSM goes to DEEP when the counter reaches DEEP_CYCLES-1.
- DEEP: wake_req=1 or activity_in=1 goes to WAKE. The counter is held at 0.
- WAKE:
  - Counter increments every cycle; the FSM goes to ACTIVE when the counter reaches WAKE_CYCLES-1.
  - activity_in, sleep_req and wake_req are ignored.
- Output decode per mode:
  - ACTIVE: clk_en 1, drive 11, hold 0.
  - LIGHT: clk_en 1, drive 01, hold 0.
  - DEEP: clk_en 0, drive 00, hold 1.
  - WAKE: clk_en 1, drive 01, hold 1 except on the final WAKE cycle, where hold is 0.
- Simultaneous events:
  - wake_req has priority over sleep_req.
  - In ACTIVE, activity_in=1 has priority over sleep_req, so the FSM stays in ACTIVE.
  - In LIGHT, the wake/activity exit has priority over a DEEP timeout on the same cycle.
- Counter arithmetic saturates at 2^CNT_W-1 and never wraps.

## Timing
- All outputs are registered; none has a combinational path from any input.
- A condition sampled at edge N produces the new mode_out and decoded outputs after edge N, visible in cycle N+1.
- mode_chg_pulse is high for exactly the first cycle of the new mode.
- Idle entry: IDLE_CYCLES inactive cycles, and mode_out=01 appears the cycle after the last of them.
- WAKE lasts exactly WAKE_CYCLES cycles, so DEEP-to-ACTIVE latency is 1+WAKE_CYCLES cycles after the wake edge.
- Reset values: mode_out=00, clk_en_out=1, pad_drive_out=11, pad_hold_out=0, mode_chg_pulse=0, counter=0.
- Reset asserted mid-sequence (e.g. in DEEP or WAKE) returns the block to ACTIVE asynchronously, with no pulse.

## Configuration
- PMU_DEEP_SLEEP_EN defined: full behaviour as described above.
- PMU_DEEP_SLEEP_EN undefined:
  - The LIGHT timeout is removed, so LIGHT persists until wake_req or activity_in.
  - DEEP and WAKE are unreachable and their logic is not generated.
  - clk_en_out is constant 1 and pad_hold_out is constant 0.

## Structure
- Shared package pmu_pkg contains:
  - the mode enum pmu_mode_e (ACTIVE, LIGHT, DEEP, WAKE with the encodings above);
  - the drive constants DRV_FULL=11, DRV_LOW=01, DRV_OFF=00.
- One sub-module, pmu_cycle_counter, implements the saturating CNT_W counter with clear, increment and terminal-compare ports.

## Test plan
- Idle entry: reset released, then activity_in=0 with defaults → mode_out=01, pad_drive_out=01 and one mode_chg_pulse, 16 cycles after release. A single activity_in=1 at cycle 10 restarts the count, so entry is 16 cycles after that pulse.
- Deep entry: stay idle in LIGHT for 64 cycles → mode_out=10, clk_en_out=0, pad_hold_out=1, pad_drive_out=00.
- Wake from deep: in DEEP, pulse wake_req for 1 cycle → WAKE for exactly 4 cycles. pad_hold_out drops on the 4th WAKE cycle, then mode_out=00 with drive 11.
- Simultaneous requests: in ACTIVE, sleep_req=1 and activity_in=1 together → stays in ACTIVE. In LIGHT, wake_req=1 and sleep_req=1 together → returns to ACTIVE.
- Reset in WAKE: assert rst_n_in=0 on the 2nd WAKE cycle → outputs take their reset values immediately with no edge needed, and no mode_chg_pulse.
- Build with PMU_DEEP_SLEEP_EN undefined: 200 idle cycles → mode_out stays 01 and clk_en_out stays 1 throughout.
